// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache controller
module dcache_ctrl #(
  parameter int INDEX_BITS  = 5,
  parameter int OFFSET_BITS = 5,
  parameter int LINE_W      = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);
  localparam int TAG_BITS  = 32 - INDEX_BITS - OFFSET_BITS;
  localparam int LINES     = 1 << INDEX_BITS;
  localparam int WORD_BITS = OFFSET_BITS - 2;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
  state_t state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_BITS-1:0] tag_q [LINES];
  logic [LINE_W-1:0] data_q [LINES];
  logic [TAG_BITS-1:0] tag;
  logic [INDEX_BITS-1:0] idx;
  logic [WORD_BITS-1:0] word;
  logic hit, fill, store_hit, unused;
  logic [LINE_W-1:0] line_d;
  assign tag       = cpu_addr_i[31 -: TAG_BITS];
  assign idx       = cpu_addr_i[OFFSET_BITS +: INDEX_BITS];
  assign word      = cpu_addr_i[2 +: WORD_BITS];
  assign unused    = ^cpu_addr_i[1:0];
  assign hit       = cpu_req_i & (state_q == IDLE) & valid_q[idx] & (tag_q[idx] == tag);
  assign fill      = (state_q == ALLOCATE) & mem_ack_i;
  assign store_hit = hit & cpu_we_i;
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    line_d  = data_q[idx];
    line_d[{word, 5'b0} +: 32] = cpu_data_i;
    if (state_q == IDLE && cpu_req_i && !hit)
      state_d = (valid_q[idx] & dirty_q[idx]) ? WRITEBACK : ALLOCATE;
    if (state_q == WRITEBACK && mem_ack_i)
      state_d = ALLOCATE;
    if (fill) begin
      state_d      = IDLE;
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
      line_d       = mem_data_i;
    end
    if (store_hit)
      dirty_d[idx] = 1'b1;
  end
  assign cpu_stall_o = (state_q != IDLE) | (cpu_req_i & !hit);
  assign cpu_data_o  = (hit & !cpu_we_i) ? data_q[idx][{word, 5'b0} +: 32] : '0;
  assign mem_req_o   = state_q != IDLE;
  assign mem_we_o    = state_q == WRITEBACK;
  // Victim address comes from the stored tag, fill address from the CPU tag.
  assign mem_addr_o  = (state_q == WRITEBACK) ? {tag_q[idx], idx, {OFFSET_BITS{1'b0}}} :
                       (state_q == ALLOCATE)  ? {tag, idx, {OFFSET_BITS{1'b0}}} : '0;
  assign mem_data_o  = (state_q == WRITEBACK) ? data_q[idx] : '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i && (store_hit || fill))
      data_q[idx] <= line_d;
    if (!rst_i && fill)
      tag_q[idx] <= tag;
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed plus random accesses against a line-level cache/memory model
module tb_dcache_ctrl;
  logic clk = 0, rst_i = 1;
  logic cpu_req_i = 0, cpu_we_i = 0, mem_ack_i = 0;
  logic [31:0] cpu_addr_i = 0, cpu_data_i = 0;
  logic [255:0] mem_data_i = 0;
  logic [31:0] cpu_data_o, mem_addr_o;
  logic cpu_stall_o, mem_req_o, mem_we_o;
  logic [255:0] mem_data_o;
  int total = 0, bad = 0;
  bit mv [32];
  bit md [32];
  logic [21:0] mt [32];
  logic [255:0] ml [32];
  logic [255:0] bmem [logic [31:0]];
  logic [255:0] last_wb, seed_line;
  logic [31:0] last_rd;

  dcache_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .cpu_stall_o(cpu_stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tg, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tg, obs, exp);
    end
  endtask

  function automatic logic [255:0] rd_mem(input logic [31:0] la);
    logic [255:0] r;
    if (bmem.exists(la)) return bmem[la];
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = la ^ (w << 2) ^ 32'hA5A5_0000;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mv[i] = 0;
      md[i] = 0;
    end
  endtask

  task automatic idle(input int n, input bit ack);
    cpu_req_i = 0;
    for (int k = 0; k < n; k++) begin
      mem_ack_i = ack;
      mem_data_i = {8{$urandom}};
      @(negedge clk);
      chk("idle_stall", cpu_stall_o, 0);
      chk("idle_memreq", mem_req_o, 0);
      @(posedge clk); #1;
      mem_ack_i = 0;
    end
  endtask

  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d, input int dw, input int da);
    logic [4:0] idx;
    logic [21:0] tg;
    logic [31:0] la;
    logic [255:0] fl;
    int w;
    idx = a[9:5];
    tg = a[31:10];
    w = int'(a[4:2]);
    cpu_req_i = 1; cpu_we_i = we; cpu_addr_i = a; cpu_data_i = d;
    if (!(mv[idx] && mt[idx] == tg)) begin
      @(negedge clk);
      chk("miss_stall", cpu_stall_o, 1);
      chk("miss_memreq", mem_req_o, 0);
      chk("miss_data", cpu_data_o, 0);
      @(posedge clk); #1;
      if (mv[idx] && md[idx]) begin
        la = {mt[idx], idx, 5'b0};
        for (int k = 1; k <= dw; k++) begin
          @(negedge clk);
          chk("wb_req", {mem_req_o, mem_we_o, cpu_stall_o}, 3'b111);
          chk("wb_addr", mem_addr_o, la);
          chk("wb_data", mem_data_o, ml[idx]);
          last_wb = mem_data_o;
          if (k == dw) mem_ack_i = 1;
          @(posedge clk); #1;
          mem_ack_i = 0;
        end
        bmem[la] = ml[idx];
      end
      la = {tg, idx, 5'b0};
      fl = rd_mem(la);
      for (int k = 1; k <= da; k++) begin
        @(negedge clk);
        chk("al_req", {mem_req_o, mem_we_o, cpu_stall_o}, 3'b101);
        chk("al_addr", mem_addr_o, la);
        chk("al_mdata", mem_data_o, 0);
        chk("al_cdata", cpu_data_o, 0);
        if (k == da) begin
          mem_ack_i = 1;
          mem_data_i = fl;
        end
        @(posedge clk); #1;
        mem_ack_i = 0;
        mem_data_i = {8{$urandom}};
      end
      mv[idx] = 1; md[idx] = 0; mt[idx] = tg; ml[idx] = fl;
    end
    @(negedge clk);
    chk("hit_stall", cpu_stall_o, 0);
    chk("hit_memreq", mem_req_o, 0);
    chk(we ? "st_data" : "ld_data", cpu_data_o, we ? 32'h0 : ml[idx][w*32 +: 32]);
    last_rd = cpu_data_o;
    @(posedge clk); #1;
    if (we) begin
      ml[idx][w*32 +: 32] = d;
      md[idx] = 1;
    end
    cpu_req_i = 0; cpu_we_i = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_i = 0;
    @(negedge clk);
    chk("rst_stall", cpu_stall_o, 0);
    chk("rst_memreq", {mem_req_o, mem_we_o}, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_cdata", cpu_data_o, 0);
    chk("rst_mdata", mem_data_o, 0);
    @(posedge clk); #1;
    seed_line = rd_mem(32'h40);
    seed_line[63:32] = 32'h1111_2222;
    bmem[32'h40] = seed_line;
    access(0, 32'h44, 0, 1, 3);
    chk("s1_load", last_rd, 32'h1111_2222);
    access(1, 32'h48, 32'hCAFE_F00D, 1, 1);
    access(0, 32'h48, 0, 1, 1);
    chk("s2_load", last_rd, 32'hCAFE_F00D);
    last_wb = '0;
    access(0, 32'h440, 0, 2, 2);
    chk("s3_wb_word2", last_wb[95:64], 32'hCAFE_F00D);
    access(1, 32'h80, 32'hDEAD_BEEF, 1, 2);
    last_wb = '0;
    access(0, 32'h480, 0, 1, 1);
    chk("s4_wb_word0", last_wb[31:0], 32'hDEAD_BEEF);
    idle(3, 1);
    access(0, 32'h440, 0, 1, 1);
    cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h100;
    @(negedge clk);
    chk("s5_miss", cpu_stall_o, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("s5_alloc", {mem_req_o, mem_we_o}, 2'b10);
    @(posedge clk); #1;
    rst_i = 1; cpu_req_i = 0;
    @(posedge clk); #1;
    rst_i = 0; mem_ack_i = 1; mem_data_i = {8{$urandom}};
    model_reset();
    @(negedge clk);
    chk("s5_req", {mem_req_o, mem_we_o}, 0);
    chk("s5_addr", mem_addr_o, 0);
    chk("s5_stall", cpu_stall_o, 0);
    chk("s5_cdata", cpu_data_o, 0);
    @(posedge clk); #1;
    mem_ack_i = 0;
    idle(1, 0);
    access(0, 32'h100, 0, 1, 1);
    access(0, 32'h440, 0, 1, 2);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) idle(1, 1'($urandom_range(0, 1)));
      else access(1'($urandom_range(0, 1)),
                  (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5) |
                  (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)),
                  $urandom, $urandom_range(1, 3), $urandom_range(1, 3));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
